// File: rtl/commit_stage_multi.sv
// N-wide in-order retire: up to COMMIT_W head entries per cycle, combinational enables, registered redirect.
// Stalls (retires nothing) on an invalid lane, for the redirect cycle and for FLUSH_CYCLES after it.
module commit_stage_multi #(
  parameter int ROBsize      = 16,
  parameter int COMMIT_W     = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32,
  localparam int ROBsizeLog  = $clog2(ROBsize+1),
  localparam int RC_W        = $clog2(COMMIT_W+1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [79*COMMIT_W-1:0]         ROBcommitReadData_i,
  input  logic [ROBsizeLog-1:0]          ROBhead_i,
  output logic [RC_W-1:0]                ROBretireCount_o,
  output logic [5*COMMIT_W-1:0]          mapCommitReadAddr_o,
  input  logic [ROBsizeLog*COMMIT_W-1:0] mapCommitReadData_i,
  output logic [31:0]                    mapResets_o,
  output logic [5*COMMIT_W-1:0]          regCommitAddr_o,
  input  logic [64*COMMIT_W-1:0]         regCommitRead_i,
  output logic [5*COMMIT_W-1:0]          WriteRegister_o,
  output logic [64*COMMIT_W-1:0]         WriteData_o,
  output logic [COMMIT_W-1:0]            RegWrite_o,
  output logic [63:0]                    writeAddrMem_o,
  output logic [63:0]                    writeDataMem_o,
  output logic                           writeEnMem_o,
  input  logic                           LSQflush_i,
  input  logic [63:0]                    LSQPC_i,
  output logic [COMMIT_W-1:0]            LSQretire_o,
  output logic                           needToRestore_o,
  output logic [63:0]                    restorePoint_o,
  output logic [CNT_W-1:0]               retiredCount_o
);
  localparam int FC_W = $clog2(FLUSH_CYCLES+1);

  typedef enum logic [1:0] {RUN, REDIRECT, FLUSH} state_e;

  state_e           state_q;
  logic [FC_W-1:0]  flush_cnt_q;
  logic [63:0]      target_q, target_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] retired_q;

  logic                restore_d;
  logic [RC_W-1:0]     count_d;
  logic [COMMIT_W-1:0] wr_lane, reg_write, lsq_ret;
  logic [31:0]         map_resets;
  logic                st_en;
  logic [63:0]         st_addr, st_data;

  logic                  open, taken, restore_k, is_wr, is_st, is_ld;
  logic                  c_f, v_f, z_f, n_f;
  logic [3:0]            cmd;
  logic [4:0]            rd;
  logic [63:0]           data, rval, tgt_k;
  int                    tag_int;
  logic [ROBsizeLog-1:0] tag;

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_lane
    assign mapCommitReadAddr_o[k*5 +: 5] = ROBcommitReadData_i[k*79+70 +: 5];
    assign regCommitAddr_o[k*5 +: 5]     = ROBcommitReadData_i[k*79+70 +: 5];
    assign WriteRegister_o[k*5 +: 5]     = ROBcommitReadData_i[k*79+70 +: 5];
    assign WriteData_o[k*64 +: 64]       = ROBcommitReadData_i[k*79 +: 64];
  end

  always_comb begin
    open       = (state_q == RUN) && !reset_i;
    flags_d    = flags_q;
    target_d   = target_q;
    restore_d  = 1'b0;
    count_d    = '0;
    wr_lane    = '0;
    lsq_ret    = '0;
    map_resets = '0;
    st_en      = 1'b0;
    st_addr    = '0;
    st_data    = '0;
    taken      = 1'b0;
    restore_k  = 1'b0;
    is_wr      = 1'b0;
    is_st      = 1'b0;
    is_ld      = 1'b0;
    {c_f, v_f, z_f, n_f} = flags_q;
    cmd        = '0;
    rd         = '0;
    data       = '0;
    rval       = '0;
    tgt_k      = '0;
    tag_int    = 0;
    tag        = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cmd  = ROBcommitReadData_i[k*79+75 +: 4];
      rd   = ROBcommitReadData_i[k*79+70 +: 5];
      data = ROBcommitReadData_i[k*79 +: 64];
      rval = regCommitRead_i[k*64 +: 64];
      // Branches see flags forwarded from older lanes of this same group.
      {c_f, v_f, z_f, n_f} = flags_d;
      case (rd)
        5'd0:    taken = z_f;
        5'd1:    taken = !z_f;
        5'd10:   taken = (n_f == v_f);
        5'd11:   taken = (n_f != v_f);
        5'd12:   taken = !z_f && (n_f == v_f);
        default: taken = z_f || (n_f != v_f);
      endcase
      restore_k = 1'b0;
      tgt_k     = data;
      is_wr     = 1'b0;
      is_st     = 1'b0;
      is_ld     = 1'b0;
      case (cmd)
        4'd0:       is_wr = 1'b1;
        4'd1: begin
          is_st     = 1'b1;
          restore_k = LSQflush_i;
          tgt_k     = LSQPC_i;
        end
        4'd2, 4'd3: restore_k = taken ^ cmd[0];
        4'd4:       restore_k = (rval == 64'd0);
        4'd5:       restore_k = (rval != 64'd0);
        4'd6: begin
          restore_k = (rval != data);
          tgt_k     = rval;
        end
        4'd7:       is_wr = 1'b1;
        4'd9: begin
          is_wr = 1'b1;
          is_ld = 1'b1;
        end
        default: ;
      endcase
      tag_int = (int'(ROBhead_i) + k) % ROBsize;
      tag     = tag_int[ROBsizeLog-1:0];
      if (open && ROBcommitReadData_i[k*79+64]) begin
        count_d    = count_d + RC_W'(1);
        wr_lane[k] = is_wr;
        lsq_ret[k] = is_ld;
        if (is_wr && mapCommitReadData_i[k*ROBsizeLog +: ROBsizeLog] == tag)
          map_resets[rd] = 1'b1;
        if (ROBcommitReadData_i[k*79+69])
          flags_d = ROBcommitReadData_i[k*79+65 +: 4];
        if (is_st) begin
          st_en   = 1'b1;
          st_addr = data;
          st_data = rval;
        end
        if (restore_k) begin
          restore_d = 1'b1;
          target_d  = tgt_k;
        end
        if (restore_k || is_st)
          open = 1'b0;
      end else begin
        open = 1'b0;
      end
    end
    // Only the youngest committing writer of a given rd reaches the regfile.
    for (int k = 0; k < COMMIT_W; k++) begin
      reg_write[k] = wr_lane[k];
      for (int j = k + 1; j < COMMIT_W; j++)
        if (wr_lane[j] && ROBcommitReadData_i[j*79+70 +: 5] == ROBcommitReadData_i[k*79+70 +: 5])
          reg_write[k] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      target_q    <= '0;
      flags_q     <= '0;
      retired_q   <= '0;
    end else begin
      flags_q   <= flags_d;
      retired_q <= retired_q + CNT_W'(count_d);
      case (state_q)
        RUN: begin
          if (restore_d) begin
            state_q  <= REDIRECT;
            target_q <= target_d;
          end
        end
        REDIRECT: begin
          state_q     <= FLUSH;
          flush_cnt_q <= FC_W'(FLUSH_CYCLES - 1);
        end
        FLUSH: begin
          if (flush_cnt_q == '0) state_q <= RUN;
          else                   flush_cnt_q <= flush_cnt_q - FC_W'(1);
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign ROBretireCount_o = count_d;
  assign RegWrite_o       = reg_write;
  assign mapResets_o      = map_resets;
  assign LSQretire_o      = lsq_ret;
  assign writeEnMem_o     = st_en;
  assign writeAddrMem_o   = st_addr;
  assign writeDataMem_o   = st_data;
  assign needToRestore_o  = (state_q == REDIRECT) && !reset_i;
  assign restorePoint_o   = needToRestore_o ? target_q : 64'd0;
  assign retiredCount_o   = retired_q;

endmodule
